// File: rtl/textbox_pkg.sv
// Shared constants and state type for the textbox character buffer.
package textbox_pkg;

    localparam logic [7:0] CH_BS     = 8'h08;
    localparam logic [7:0] CH_FF     = 8'h0C;
    localparam logic [7:0] CH_CR     = 8'h0D;
    localparam logic [7:0] CH_BLANK  = 8'h20;

    localparam logic [7:0] PRINT_MIN = 8'h20;
    localparam logic [7:0] PRINT_MAX = 8'h7E;

    typedef enum logic {
        IDLE,
        CLEAR
    } tb_state_t;

endpackage

// File: rtl/textbox_buffer.sv
// One-line character buffer: byte stream edits a back buffer with a cursor,
// and the front buffer driving the renderer is refreshed only at frame starts.
module textbox_buffer
    import textbox_pkg::*;
#(
    parameter int unsigned COLS  = 8,
    parameter int unsigned CBITS = $clog2(COLS),
    parameter logic [7:0]  BLANK = CH_BLANK
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    input  logic             frame_start,
    output logic [7:0]       chars [COLS-1:0],
    output logic [CBITS-1:0] cursor,
    output logic             busy
);

    localparam logic [CBITS-1:0] LAST = CBITS'(COLS - 1);

    tb_state_t        state, state_next;
    logic [7:0]       back [COLS-1:0];
    logic [CBITS-1:0] clr_idx, clr_next;
    logic [CBITS-1:0] cursor_next;
    logic             commit_pending, pending_next;
    logic             accept, commit;
    logic             wr_en;
    logic [CBITS-1:0] wr_idx;
    logic [7:0]       wr_data;

    assign in_ready = (state == IDLE);
    assign busy     = (state == CLEAR);
    assign accept   = in_valid && in_ready;
    // Commit samples back before any write on the same edge.
    assign commit   = (state == IDLE) && (frame_start || commit_pending);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        cursor_next  = cursor;
        clr_next     = clr_idx;
        pending_next = 1'b0;
        wr_en        = 1'b0;
        wr_idx       = cursor;
        wr_data      = BLANK;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (in_data >= PRINT_MIN && in_data <= PRINT_MAX) begin
                        wr_en       = 1'b1;
                        wr_data     = in_data;
                        cursor_next = (cursor == LAST) ? '0 : cursor + 1'b1;
                    end else if (in_data == CH_CR) begin
                        cursor_next = '0;
                    end else if (in_data == CH_BS) begin
                        if (cursor != '0) begin
                            wr_en       = 1'b1;
                            wr_idx      = cursor - 1'b1;
                            cursor_next = cursor - 1'b1;
                        end
                    end else if (in_data == CH_FF) begin
                        state_next = CLEAR;
                        clr_next   = '0;
                    end
                end
            end
            CLEAR: begin
                pending_next = commit_pending || frame_start;
                wr_en        = 1'b1;
                wr_idx       = clr_idx;
                clr_next     = clr_idx + 1'b1;
                if (clr_idx == LAST) begin
                    state_next  = IDLE;
                    cursor_next = '0;
                    clr_next    = '0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < COLS; i++) begin
                back[i]  <= BLANK;
                chars[i] <= BLANK;
            end
            cursor         <= '0;
            clr_idx        <= '0;
            commit_pending <= 1'b0;
        end else begin
            if (commit) begin
                for (int unsigned i = 0; i < COLS; i++) begin
                    chars[i] <= back[i];
                end
            end
            if (wr_en) begin
                back[wr_idx] <= wr_data;
            end
            cursor         <= cursor_next;
            clr_idx        <= clr_next;
            commit_pending <= pending_next;
        end
    end

endmodule
